// File: rtl/queue_stream.sv
`default_nettype none
// ============================================================================
//  Module      : queue_stream
//  Description : Single-clock circular FIFO with full 2^LEN_NBITS usable depth,
//                fill count, programmable almost-full/almost-empty flags,
//                synchronous flush, overflow/underflow pulses and selectable
//                registered or first-word-fall-through read data.
//  Revision    : 1.0  initial release
// ============================================================================
module queue_stream #(
    parameter int WIDTH              = 32,
    parameter int LEN_NBITS          = 6,
    parameter int FWFT               = 0,
    parameter int ALMOST_FULL_LEVEL  = (1 << LEN_NBITS) - 4,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 write,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 read,
    output logic [WIDTH-1:0]     data_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [LEN_NBITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int                 c_DEPTH     = 1 << LEN_NBITS;
    localparam logic [LEN_NBITS:0] c_AF_LEVEL  = ALMOST_FULL_LEVEL[LEN_NBITS:0];
    localparam logic [LEN_NBITS:0] c_AE_LEVEL  = ALMOST_EMPTY_LEVEL[LEN_NBITS:0];
    localparam logic [LEN_NBITS:0] c_PTR_ONE   = {{LEN_NBITS{1'b0}}, 1'b1};

    // Storage is deliberately left without reset so it maps onto RAM.
    logic [WIDTH-1:0]     r_mem [c_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [LEN_NBITS:0]   r_wr_ptr;
    logic [LEN_NBITS:0]   r_rd_ptr;
    logic [LEN_NBITS:0]   r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic [LEN_NBITS-1:0] w_wr_idx;
    logic [LEN_NBITS-1:0] w_rd_idx;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_read_accept;
    logic                 w_write_accept;
    logic [LEN_NBITS:0]   w_count_inc;
    logic [LEN_NBITS:0]   w_count_dec;

    assign w_wr_idx = r_wr_ptr[LEN_NBITS-1:0];
    assign w_rd_idx = r_rd_ptr[LEN_NBITS-1:0];

    // Status depends only on registered state, so read/write never reach it
    // combinationally.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) &&
                     (r_wr_ptr[LEN_NBITS] != r_rd_ptr[LEN_NBITS]);

    // Flush overrides both requests; a write into a full queue is allowed
    // when a read frees a slot in the same cycle.
    assign w_read_accept  = read  && !w_empty && !flush;
    assign w_write_accept = write && (!w_full || w_read_accept) && !flush;

    assign w_count_inc = {{LEN_NBITS{1'b0}}, w_write_accept};
    assign w_count_dec = {{LEN_NBITS{1'b0}}, w_read_accept};

    // Pointer, occupancy and error-pulse bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_write_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_read_accept) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count     <= r_count + w_count_inc - w_count_dec;
            r_overflow  <= write && !w_write_accept;
            r_underflow <= read  && !w_read_accept;
        end
    end

    // Data storage write port.
    always_ff @(posedge clock) begin
        if (w_write_accept) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; zero while nothing is stored.
            assign data_out = w_empty ? '0 : r_mem[w_rd_idx];
        end else begin : g_registered
            logic [WIDTH-1:0] r_data_out;

            // Registered read: word appears the cycle after an accepted read
            // and holds otherwise, including across rejected reads.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_data_out <= '0;
                end else if (flush) begin
                    r_data_out <= '0;
                end else if (w_read_accept) begin
                    r_data_out <= r_mem[w_rd_idx];
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign almost_full  = (r_count >= c_AF_LEVEL);
    assign almost_empty = (r_count <= c_AE_LEVEL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_queue_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_queue_stream
//  Description : Self-checking bench for queue_stream. Two instances (registered
//                and FWFT read) share one stimulus stream; a queue-based model
//                supplies expected values alongside a hand-written vector table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_queue_stream;

    localparam int c_W   = 16;
    localparam int c_LEN = 2;
    localparam int c_DEP = 1 << c_LEN;
    localparam int c_AF  = 3;
    localparam int c_AE  = 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             write;
    logic             read;
    logic [c_W-1:0]   data_in;

    logic [c_W-1:0]   d0_data_out, d1_data_out;
    logic             d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un;
    logic             d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un;
    logic [c_LEN:0]   d0_count, d1_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    queue_stream #(
        .WIDTH(c_W), .LEN_NBITS(c_LEN), .FWFT(0),
        .ALMOST_FULL_LEVEL(c_AF), .ALMOST_EMPTY_LEVEL(c_AE)
    ) u_dut_reg (
        .clock(clock), .reset_n(reset_n), .flush(flush), .write(write),
        .data_in(data_in), .read(read), .data_out(d0_data_out),
        .full(d0_full), .empty(d0_empty), .almost_full(d0_af),
        .almost_empty(d0_ae), .count(d0_count), .overflow(d0_ov),
        .underflow(d0_un)
    );

    queue_stream #(
        .WIDTH(c_W), .LEN_NBITS(c_LEN), .FWFT(1),
        .ALMOST_FULL_LEVEL(c_AF), .ALMOST_EMPTY_LEVEL(c_AE)
    ) u_dut_fwft (
        .clock(clock), .reset_n(reset_n), .flush(flush), .write(write),
        .data_in(data_in), .read(read), .data_out(d1_data_out),
        .full(d1_full), .empty(d1_empty), .almost_full(d1_af),
        .almost_empty(d1_ae), .count(d1_count), .overflow(d1_ov),
        .underflow(d1_un)
    );

    // ---------------- behavioural reference model ----------------
    logic [c_W-1:0] mq[$];
    logic [c_W-1:0] m_d0;
    logic           m_ov, m_un;

    task automatic model_reset();
        mq.delete();
        m_d0 = '0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic model_step(input logic fl, input logic wr, input logic rd,
                              input logic [c_W-1:0] din);
        bit ra, wa;
        if (fl) begin
            mq.delete();
            m_d0 = '0;
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            ra = rd && (mq.size() > 0);
            wa = wr && ((mq.size() < c_DEP) || ra);
            if (ra) m_d0 = mq.pop_front();
            if (wa) mq.push_back(din);
            m_ov = wr && !wa;
            m_un = rd && !ra;
        end
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt,
                               input logic [c_W-1:0] e_d0,
                               input logic [c_W-1:0] e_d1,
                               input logic e_ov, input logic e_un);
        chk({tag, " count"},     32'(d0_count), 32'(cnt));
        chk({tag, " count_f"},   32'(d1_count), 32'(cnt));
        chk({tag, " empty"},     32'(d0_empty), 32'(cnt == 0));
        chk({tag, " full"},      32'(d0_full),  32'(cnt == c_DEP));
        chk({tag, " empty_f"},   32'(d1_empty), 32'(cnt == 0));
        chk({tag, " full_f"},    32'(d1_full),  32'(cnt == c_DEP));
        chk({tag, " alm_full"},  32'(d0_af),    32'(cnt >= c_AF));
        chk({tag, " alm_empty"}, 32'(d0_ae),    32'(cnt <= c_AE));
        chk({tag, " overflow"},  32'(d0_ov),    32'(e_ov));
        chk({tag, " underflow"}, 32'(d0_un),    32'(e_un));
        chk({tag, " ovf_f"},     32'(d1_ov),    32'(e_ov));
        chk({tag, " unf_f"},     32'(d1_un),    32'(e_un));
        chk({tag, " dout_reg"},  32'(d0_data_out), 32'(e_d0));
        chk({tag, " dout_fwft"}, 32'(d1_data_out), 32'(e_d1));
    endtask

    task automatic check_model(input string tag);
        check_state(tag, mq.size(), m_d0,
                    (mq.size() > 0) ? mq[0] : '0, m_ov, m_un);
    endtask

    // Apply one cycle of inputs, advance the model and sample after the edge.
    task automatic step(input logic fl, input logic wr, input logic rd,
                        input logic [c_W-1:0] din, input string tag);
        flush   = fl;
        write   = wr;
        read    = rd;
        data_in = din;
        @(posedge clock);
        #1;
        model_step(fl, wr, rd, din);
        check_model(tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic           fl, wr, rd;
        logic [c_W-1:0] din;
        int             cnt;
        logic [c_W-1:0] d0, d1;
        logic           ov, un;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic wr, input logic rd,
                                input logic [c_W-1:0] din, input int cnt,
                                input logic [c_W-1:0] d0, input logic [c_W-1:0] d1,
                                input logic ov, input logic un);
        vec_t v;
        v.fl = fl; v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
        v.d0 = d0; v.d1 = d1; v.ov = ov; v.un = un;
        return v;
    endfunction

    initial begin
        int lvl;
        reset_n = 1'b0;
        flush   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;
        model_reset();

        // fill, overflow, drain, underflow
        vecs.push_back(mk(0,1,0,16'hA, 1, 0, 16'hA, 0,0));
        vecs.push_back(mk(0,1,0,16'hB, 2, 0, 16'hA, 0,0));
        vecs.push_back(mk(0,1,0,16'hC, 3, 0, 16'hA, 0,0));
        vecs.push_back(mk(0,1,0,16'hD, 4, 0, 16'hA, 0,0));
        vecs.push_back(mk(0,1,0,16'hF, 4, 0, 16'hA, 1,0));
        vecs.push_back(mk(0,0,0,16'h0, 4, 0, 16'hA, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 3, 16'hA, 16'hB, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 2, 16'hB, 16'hC, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 1, 16'hC, 16'hD, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 0, 16'hD, 16'h0, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 0, 16'hD, 16'h0, 0,1));
        vecs.push_back(mk(0,0,0,16'h0, 0, 16'hD, 16'h0, 0,0));
        // refill, simultaneous read+write at full, drain
        vecs.push_back(mk(0,1,0,16'h1, 1, 16'hD, 16'h1, 0,0));
        vecs.push_back(mk(0,1,0,16'h2, 2, 16'hD, 16'h1, 0,0));
        vecs.push_back(mk(0,1,0,16'h3, 3, 16'hD, 16'h1, 0,0));
        vecs.push_back(mk(0,1,0,16'h4, 4, 16'hD, 16'h1, 0,0));
        vecs.push_back(mk(0,1,1,16'hE, 4, 16'h1, 16'h2, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 3, 16'h2, 16'h3, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 2, 16'h3, 16'h4, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 1, 16'h4, 16'hE, 0,0));
        vecs.push_back(mk(0,0,1,16'h0, 0, 16'hE, 16'h0, 0,0));
        // simultaneous read+write on empty queue
        vecs.push_back(mk(0,1,1,16'h5, 1, 16'hE, 16'h5, 0,1));
        vecs.push_back(mk(0,0,0,16'h0, 1, 16'hE, 16'h5, 0,0));
        // flush beats write and read
        vecs.push_back(mk(0,1,0,16'h6, 2, 16'hE, 16'h5, 0,0));
        vecs.push_back(mk(0,1,0,16'h7, 3, 16'hE, 16'h5, 0,0));
        vecs.push_back(mk(1,1,0,16'h8, 0, 16'h0, 16'h0, 0,0));
        vecs.push_back(mk(1,1,1,16'h9, 0, 16'h0, 16'h0, 0,0));

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check_state("reset", 0, '0, '0, 1'b0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].din,
                 $sformatf("vec%0d_model", i));
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].d0,
                        vecs[i].d1, vecs[i].ov, vecs[i].un);
        end

        // almost flags stepped through every occupancy from a clean start
        for (int i = 0; i <= c_DEP; i++) begin
            lvl = i;
            chk($sformatf("af_level%0d", lvl), 32'(d0_af), 32'(mq.size() >= c_AF));
            chk($sformatf("ae_level%0d", lvl), 32'(d0_ae), 32'(mq.size() <= c_AE));
            if (i < c_DEP) step(0, 1, 0, c_W'(16'h40 + i), $sformatf("lvl%0d", i));
        end
        step(1, 0, 0, '0, "lvl_flush");

        // ten write/read pairs crossing the pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, c_W'(16'h100 + i), $sformatf("wrap_w%0d", i));
            step(0, 0, 1, '0, $sformatf("wrap_r%0d", i));
            chk($sformatf("wrap_data%0d", i), 32'(d0_data_out), 32'(16'h100 + i));
        end

        // flush at count 3 with write asserted
        step(0, 1, 0, 16'h21, "fl3_w0");
        step(0, 1, 0, 16'h22, "fl3_w1");
        step(0, 1, 0, 16'h23, "fl3_w2");
        step(1, 1, 0, 16'h24, "fl3_flush");

        // randomized traffic, write-heavy then read-heavy
        for (int i = 0; i < 600; i++) begin
            logic fl, wr, rd;
            int wbias;
            wbias = (i < 300) ? 65 : 35;
            fl = ($urandom_range(0, 39) == 0);
            wr = ($urandom_range(0, 99) < wbias);
            rd = ($urandom_range(0, 99) < (100 - wbias));
            step(fl, wr, rd, c_W'($urandom), $sformatf("rnd%0d", i));
        end

        // asynchronous reset in the middle of a burst
        step(0, 1, 0, 16'h31, "burst0");
        step(0, 1, 1, 16'h32, "burst1");
        step(0, 1, 0, 16'h33, "burst2");
        write   = 1'b1;
        read    = 1'b1;
        data_in = 16'h34;
        reset_n = 1'b0;
        #2;
        model_reset();
        check_state("async_reset", 0, '0, '0, 1'b0, 1'b0);
        write = 1'b0;
        read  = 1'b0;
        @(posedge clock);
        #1;
        check_state("reset_held", 0, '0, '0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step(0, 1, 0, 16'h55, "post_reset_w");
        step(0, 0, 1, '0, "post_reset_r");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
